bpu_hist_ctrl: RTL

//  Sequences the global-history gshare predictor in stage IF1: owns speculative history (fbhr) and committed history (wbhr).

---
 rtl/bpu_hist_ctrl_pkg.sv | 15 +
 rtl/bpu_pred_fifo.sv | 52 +++++
 rtl/bpu_hist_ctrl.sv | 84 ++++++++
 3 files changed

// File: rtl/bpu_hist_ctrl_pkg.sv
// Shared defaults and the history shift helper for the gshare history controller.
// The helper works on a fixed wide vector; callers cast to and from their own history width.
package bpu_hist_ctrl_pkg;

  localparam int BHR_WIDTH_DEF = 4;
  localparam int DEPTH_DEF     = 4;
  localparam int CNT_WIDTH_DEF = 32;
  localparam int HIST_MAX      = 32;

  function automatic logic [HIST_MAX-1:0] shift_in(input logic [HIST_MAX-1:0] bhr,
                                                   input logic                b);
    return {bhr[HIST_MAX-2:0], b};
  endfunction

endpackage

// File: rtl/bpu_pred_fifo.sv
// In-order 1-bit queue of predicted directions; read data is combinational from the head,
// push/pop/clear take effect on the next edge; the caller gates push with !full_o.
module bpu_pred_fifo
  import bpu_hist_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   push_dat_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  output logic                   rd_dat_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o  = (wr_q == rd_q);
  assign full_o   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o  = wr_q - rd_q;
  assign rd_dat_o = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_i) wr_d = wr_q + (AW+1)'(1);
    if (pop_i)  rd_d = rd_q + (AW+1)'(1);
    if (clear_i) rd_d = wr_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      if (push_i) mem_q[wr_q[AW-1:0]] <= push_dat_i;
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

endmodule

// File: rtl/bpu_hist_ctrl.sv
// Speculative/committed global history for gshare plus the in-flight prediction queue.
// PHT update and mispredict are same-cycle combinational; if1_accept drops when the queue is full.
module bpu_hist_ctrl
  import bpu_hist_ctrl_pkg::*;
#(
  parameter int BHR_WIDTH = BHR_WIDTH_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   if1_br_valid,
  input  logic                   if1_pred_taken,
  output logic                   if1_accept,
  input  logic                   ex_br_valid,
  input  logic                   ex_taken,
  input  logic                   flush,
  output logic [BHR_WIDTH-1:0]   fbhr,
  output logic [BHR_WIDTH-1:0]   wbhr,
  output logic                   pht_we,
  output logic                   pht_branched,
  output logic                   mispredict,
  output logic [$clog2(DEPTH):0] inflight,
  output logic [CNT_WIDTH-1:0]   mispred_cnt
);

  logic [BHR_WIDTH-1:0] spec_bhr_q, spec_bhr_d;
  logic [BHR_WIDTH-1:0] arch_bhr_q, arch_bhr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic q_full, q_empty, q_head;
  logic pu, po, rb;

  assign if1_accept   = !q_full;
  assign po           = ex_br_valid && !q_empty;
  assign mispredict   = po && (ex_taken != q_head);
  assign rb           = mispredict || flush;
  assign pu           = if1_br_valid && if1_accept && !rb;

  assign pht_we       = po;
  assign pht_branched = ex_taken;
  assign fbhr         = spec_bhr_q;
  assign wbhr         = arch_bhr_q;
  assign mispred_cnt  = cnt_q;

  bpu_pred_fifo #(.DEPTH(DEPTH)) u_pred_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (pu),
    .push_dat_i (if1_pred_taken),
    .pop_i      (po),
    .clear_i    (rb),
    .rd_dat_o   (q_head),
    .full_o     (q_full),
    .empty_o    (q_empty),
    .count_o    (inflight)
  );

  // Rollback restores the committed history including this cycle's resolved branch.
  always_comb begin
    arch_bhr_d = arch_bhr_q;
    if (po) arch_bhr_d = BHR_WIDTH'(shift_in(HIST_MAX'(arch_bhr_q), ex_taken));

    spec_bhr_d = spec_bhr_q;
    if (rb)      spec_bhr_d = arch_bhr_d;
    else if (pu) spec_bhr_d = BHR_WIDTH'(shift_in(HIST_MAX'(spec_bhr_q), if1_pred_taken));

    cnt_d = cnt_q;
    if (mispredict && !(&cnt_q)) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spec_bhr_q <= '0;
      arch_bhr_q <= '0;
      cnt_q      <= '0;
    end else begin
      spec_bhr_q <= spec_bhr_d;
      arch_bhr_q <= arch_bhr_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
